// File: rtl/intersection_scheduler_pkg.sv
// Shared types for the intersection scheduler: phase states, directions and lamp encodings.
// The FLASH state exists only when INTERSECTION_FLASH_EN is defined.
package intersection_pkg;

`ifdef INTERSECTION_FLASH_EN
    typedef enum logic [2:0] {
        NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, ALL_RED, PED_WALK, FLASH
    } state_e;
`else
    typedef enum logic [2:0] {
        NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, ALL_RED, PED_WALK
    } state_e;
`endif

    typedef enum logic {DIR_NS, DIR_EW} dir_e;

    // Lamp vector ordering is {green, yellow, red}.
    typedef logic [2:0] lamp_t;
    localparam lamp_t LAMP_GREEN  = 3'b100;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_RED    = 3'b001;
    localparam lamp_t LAMP_OFF    = 3'b000;

endpackage

// File: rtl/intersection_scheduler_tick_gen.sv
// Timing prescaler: asserts tick on the last cycle of every TICK_DIV-cycle window.
// Unaffected by INTERSECTION_FLASH_EN.
module tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/intersection_scheduler.sv
// Demand-driven phase scheduler for a two-road intersection with a pedestrian crossing.
// Define INTERSECTION_FLASH_EN to add the flash_mode input and the flashing-yellow FLASH state.
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int TICK_DIV  = 1,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW    = 2,
    parameter int ALLRED    = 1,
    parameter int WALK      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ns_car,
    input  logic ew_car,
    input  logic ped_req,
`ifdef INTERSECTION_FLASH_EN
    input  logic flash_mode,
`endif
    output logic ns_g,
    output logic ns_y,
    output logic ns_r,
    output logic ew_g,
    output logic ew_y,
    output logic ew_r,
    output logic walk
);
    localparam int TW = $clog2(GREEN_MAX + 1);
    localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] T_YEL  = TW'(YELLOW - 1);
    localparam logic [TW-1:0] T_AR   = TW'(ALLRED - 1);
    localparam logic [TW-1:0] T_WALK = TW'(WALK - 1);

    state_e        state_q, state_d;
    dir_e          dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ped_q, ped_d;
    logic          tick;
    logic          ns_leave, ew_leave;
    lamp_t         ns_lamp, ew_lamp;
`ifdef INTERSECTION_FLASH_EN
    logic          flash_q, flash_d;
`endif

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A green yields only to opposing demand: early once minimum is served and own road is idle, forced at max.
    assign ns_leave = tick & (ew_car | ped_q) & (((timer_q >= T_GMIN) & ~ns_car) | (timer_q == T_GMAX));
    assign ew_leave = tick & (ns_car | ped_q) & (((timer_q >= T_GMIN) & ~ew_car) | (timer_q == T_GMAX));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            NS_GREEN:  if (ns_leave) state_d = NS_YELLOW;
            EW_GREEN:  if (ew_leave) state_d = EW_YELLOW;
            NS_YELLOW: if (tick && timer_q == T_YEL) begin
                state_d = ALL_RED;
                dir_d   = DIR_EW;
            end
            EW_YELLOW: if (tick && timer_q == T_YEL) begin
                state_d = ALL_RED;
                dir_d   = DIR_NS;
            end
            ALL_RED: if (tick && timer_q == T_AR) begin
                if (ped_q) state_d = PED_WALK;
                else       state_d = (dir_q == DIR_NS) ? NS_GREEN : EW_GREEN;
`ifdef INTERSECTION_FLASH_EN
                if (flash_mode) state_d = FLASH;
`endif
            end
            PED_WALK: if (tick && timer_q == T_WALK) begin
                state_d = (dir_q == DIR_NS) ? NS_GREEN : EW_GREEN;
            end
`ifdef INTERSECTION_FLASH_EN
            FLASH: if (tick && !flash_mode) begin
                state_d = ALL_RED;
                dir_d   = DIR_NS;
            end
`endif
            default: state_d = NS_GREEN;
        endcase
    end

    always_comb begin
        if (state_d != state_q)             timer_d = '0;
        else if (tick && timer_q != T_GMAX) timer_d = timer_q + 1'b1;
        else                                timer_d = timer_q;

        ped_d = ped_q;
`ifdef INTERSECTION_FLASH_EN
        if (ped_req && state_q != PED_WALK && state_q != FLASH) ped_d = 1'b1;
`else
        if (ped_req && state_q != PED_WALK) ped_d = 1'b1;
`endif
        if (state_d == PED_WALK && state_q != PED_WALK) ped_d = 1'b0;
    end

`ifdef INTERSECTION_FLASH_EN
    always_comb begin
        if (state_q != FLASH) flash_d = 1'b1;
        else if (tick)        flash_d = ~flash_q;
        else                  flash_d = flash_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NS_GREEN;
            dir_q   <= DIR_EW;
            timer_q <= '0;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            ped_q   <= ped_d;
        end
    end

`ifdef INTERSECTION_FLASH_EN
    always_ff @(posedge clk) begin
        if (rst) flash_q <= 1'b1;
        else     flash_q <= flash_d;
    end
`endif

    // Lamps decode from the registered state only.
    always_comb begin
        ns_lamp = LAMP_RED;
        ew_lamp = LAMP_RED;
        walk    = 1'b0;
        case (state_q)
            NS_GREEN:  ns_lamp = LAMP_GREEN;
            NS_YELLOW: ns_lamp = LAMP_YELLOW;
            EW_GREEN:  ew_lamp = LAMP_GREEN;
            EW_YELLOW: ew_lamp = LAMP_YELLOW;
            PED_WALK:  walk    = 1'b1;
`ifdef INTERSECTION_FLASH_EN
            FLASH: begin
                ns_lamp = flash_q ? LAMP_YELLOW : LAMP_OFF;
                ew_lamp = flash_q ? LAMP_YELLOW : LAMP_OFF;
            end
`endif
            default: ;
        endcase
    end

    assign {ns_g, ns_y, ns_r} = ns_lamp;
    assign {ew_g, ew_y, ew_r} = ew_lamp;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: a phase-level reference model predicts lamps each cycle.
// Exercises the default build; with INTERSECTION_FLASH_EN the flash_mode input is held low.
module tb_intersection_scheduler;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 8;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 3;

    logic clk = 1'b0;
    logic rst, ns_car, ew_car, ped_req;
    logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk;
`ifdef INTERSECTION_FLASH_EN
    logic flash_mode = 1'b0;
`endif

    always #5 clk = ~clk;

    intersection_scheduler #(
        .TICK_DIV  (1),
        .GREEN_MIN (GREEN_MIN),
        .GREEN_MAX (GREEN_MAX),
        .YELLOW    (YELLOW_T),
        .ALLRED    (ALLRED_T),
        .WALK      (WALK_T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ns_car  (ns_car),
        .ew_car  (ew_car),
        .ped_req (ped_req),
`ifdef INTERSECTION_FLASH_EN
        .flash_mode (flash_mode),
`endif
        .ns_g    (ns_g),
        .ns_y    (ns_y),
        .ns_r    (ns_r),
        .ew_g    (ew_g),
        .ew_y    (ew_y),
        .ew_r    (ew_r),
        .walk    (walk)
    );

    // Reference model: which phase is showing, which road it belongs to, and how many ticks it has run.
    typedef enum {K_GREEN, K_YELLOW, K_CLEAR, K_WALK} kind_e;
    bit    m_init = 0;
    kind_e m_kind = K_GREEN;
    int    m_road = 0;      // 0 = NS, 1 = EW
    int    m_elapsed = 0;
    bit    m_pend = 0;
    int    m_next = 1;

    logic [6:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [6:0] model_lamps();
        logic [2:0] ns_l, ew_l;
        logic       w;
        ns_l = 3'b001;
        ew_l = 3'b001;
        w    = 1'b0;
        case (m_kind)
            K_GREEN:  if (m_road == 0) ns_l = 3'b100; else ew_l = 3'b100;
            K_YELLOW: if (m_road == 0) ns_l = 3'b010; else ew_l = 3'b010;
            K_WALK:   w = 1'b1;
            default:  ;
        endcase
        return {ns_l, ew_l, w};
    endfunction

    task automatic model_step(input bit ns, input bit ew, input bit ped, input bit r);
        bit    new_pend, own, opp, changed;
        int    served;
        if (r) begin
            m_init = 1; m_kind = K_GREEN; m_road = 0; m_elapsed = 0; m_pend = 0; m_next = 1;
            return;
        end
        new_pend = m_pend | (ped && m_kind != K_WALK);
        served   = m_elapsed + 1;
        changed  = 0;
        case (m_kind)
            K_GREEN: begin
                own = (m_road == 0) ? ns : ew;
                opp = (m_road == 0) ? ew : ns;
                if ((opp || m_pend) && ((served >= GREEN_MIN && !own) || served >= GREEN_MAX)) begin
                    m_kind = K_YELLOW; changed = 1;
                end
            end
            K_YELLOW: if (served >= YELLOW_T) begin
                m_kind = K_CLEAR; m_next = 1 - m_road; changed = 1;
            end
            K_CLEAR: if (served >= ALLRED_T) begin
                if (m_pend) m_kind = K_WALK;
                else begin m_kind = K_GREEN; m_road = m_next; end
                changed = 1;
            end
            K_WALK: if (served >= WALK_T) begin
                m_kind = K_GREEN; m_road = m_next; changed = 1;
            end
            default: ;
        endcase
        m_elapsed = changed ? 0 : served;
        m_pend    = (changed && m_kind == K_WALK) ? 1'b0 : new_pend;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // One cycle of stimulus: inputs applied just after the edge, expectation queued for the current phase.
    task automatic drive(input bit ns, input bit ew, input bit ped, input bit r);
        @(posedge clk);
        #1;
        ns_car = ns; ew_car = ew; ped_req = ped; rst = r;
        if (m_init) exp_q.push_back(model_lamps());
        model_step(ns, ew, ped, r);
    endtask

    initial begin : monitor
        logic [6:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};
                check("lamps{ns_gyr,ew_gyr,walk}", {1'b0, a}, {1'b0, e});
                check("one_lamp_per_road", {6'd0, $onehot({ns_g, ns_y, ns_r}), $onehot({ew_g, ew_y, ew_r})}, 8'd3);
            end
        end
    end

    initial begin : stimulus
        int guard;
        int pn, pe;
        rst = 1'b1; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;

        // Reset, then idle: rest in NS green.
        drive(0, 0, 0, 1); drive(0, 0, 0, 1);
        repeat (20) drive(0, 0, 0, 0);

        // EW demand only: hand over after minimum green.
        drive(0, 0, 0, 1);
        repeat (20) drive(0, 1, 0, 0);

        // Both roads busy: max-green alternation.
        drive(0, 0, 0, 1);
        repeat (50) drive(1, 1, 0, 0);

        // Single pedestrian pulse on cycle 1, then ped held during the walk.
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        guard = 0;
        while (m_kind != K_WALK && guard < 40) begin drive(0, 0, 0, 0); guard++; end
        check("reach_walk", {7'd0, m_kind == K_WALK}, 8'd1);
        guard = 0;
        while (m_kind == K_WALK && guard < 40) begin drive(0, 0, 1, 0); guard++; end
        repeat (12) drive(0, 0, 0, 0);

        // Latch a ped request, reach EW yellow, then reset: request must be lost.
        drive(1, 0, 1, 0);
        guard = 0;
        while (!(m_kind == K_YELLOW && m_road == 1) && guard < 40) begin drive(1, 0, 0, 0); guard++; end
        check("reach_ew_yellow", {7'd0, m_kind == K_YELLOW && m_road == 1}, 8'd1);
        drive(0, 0, 0, 1);
        repeat (15) drive(0, 0, 0, 0);

        // Randomized traffic with changing densities, rare ped presses and occasional resets.
        drive(0, 0, 0, 1);
        for (int seg = 0; seg < 30; seg++) begin
            pn = $urandom_range(0, 100);
            pe = $urandom_range(0, 100);
            for (int c = 0; c < 100; c++) begin
                drive($urandom_range(0, 99) < pn, $urandom_range(0, 99) < pe,
                      $urandom_range(0, 99) < 4, $urandom_range(0, 999) < 3);
            end
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", {7'd0, exp_q.size() == 0}, 8'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
